// File: rtl/result_buffer_pkg.sv
// -----------------------------------------------------------------------------
// result_buffer_pkg
// Shared defaults for the result buffer that sits behind the adder: the data
// width of an adder result, the number of FIFO entries, and the width of the
// saturating drop counter (which also sets how far the running sum extends
// beyond the data width).
// -----------------------------------------------------------------------------
package result_buffer_pkg;

   localparam int RB_WIDTH  = 8;
   localparam int RB_DEPTH  = 4;
   localparam int RB_DROP_W = 8;

endpackage

// File: rtl/result_buffer_mem.sv
// -----------------------------------------------------------------------------
// result_buffer_mem
// Storage array for the result buffer. Writes land on the rising clock edge;
// reads are purely combinational from the supplied address, so the head entry
// is visible as soon as the read pointer points at it. The array is not reset:
// the owning FIFO never exposes an entry it has not written since reset.
//
// Ports
//   clk      in   clock, write on rising edge
//   wr_en    in   write strobe
//   wr_addr  in   write address (FIFO write pointer)
//   wr_data  in   data to store
//   rd_addr  in   read address (FIFO read pointer)
//   rd_data  out  entry at rd_addr
// -----------------------------------------------------------------------------
module result_buffer_mem
   import result_buffer_pkg::*;
#(
   parameter int WIDTH_p = RB_WIDTH,
   parameter int DEPTH_p = RB_DEPTH
) (
   input  logic                       clk,
   input  logic                       wr_en,
   input  logic [$clog2(DEPTH_p)-1:0] wr_addr,
   input  logic [WIDTH_p-1:0]         wr_data,
   input  logic [$clog2(DEPTH_p)-1:0] rd_addr,
   output logic [WIDTH_p-1:0]         rd_data
);

   logic [WIDTH_p-1:0] storeArray [DEPTH_p];

   // Registered write port; contents survive reset on purpose since they are
   // unobservable until rewritten.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         storeArray[wr_addr] <= wr_data;
      end
   end

   // Combinational read of whatever entry the read pointer selects.
   assign rd_data = storeArray[rd_addr];

endmodule

// File: rtl/result_buffer.sv
// -----------------------------------------------------------------------------
// result_buffer
// Small FIFO that captures adder results. Results arriving while the FIFO is
// full are dropped and counted in a saturating drop counter; every accepted
// result is also added into a running sum. The counter and sum can be cleared
// without disturbing the queued data.
//
// Ports
//   clk        in   clock, all state on rising edge
//   rstn       in   asynchronous active-low reset
//   in_valid   in   upstream result valid
//   in_data    in   upstream result
//   clr        in   synchronous clear of drop_cnt and sum
//   out_ready  in   downstream takes the head entry
//   out_valid  out  head entry present
//   out_data   out  head entry (driven to zero while empty)
//   count      out  occupied entries
//   full       out  count == DEPTH_p
//   empty      out  count == 0
//   drop_cnt   out  results lost while full, saturating at 255
//   sum        out  running modulo sum of accepted results
// -----------------------------------------------------------------------------
module result_buffer
   import result_buffer_pkg::*;
#(
   parameter int WIDTH_p = RB_WIDTH,
   parameter int DEPTH_p = RB_DEPTH
) (
   input  logic                         clk,
   input  logic                         rstn,
   input  logic                         in_valid,
   input  logic [WIDTH_p-1:0]           in_data,
   input  logic                         clr,
   input  logic                         out_ready,
   output logic                         out_valid,
   output logic [WIDTH_p-1:0]           out_data,
   output logic [$clog2(DEPTH_p):0]     count,
   output logic                         full,
   output logic                         empty,
   output logic [RB_DROP_W-1:0]         drop_cnt,
   output logic [WIDTH_p+RB_DROP_W-1:0] sum
);

   localparam int PTR_W = $clog2(DEPTH_p);
   localparam int CNT_W = PTR_W + 1;
   localparam int SUM_W = WIDTH_p + RB_DROP_W;

   logic [PTR_W-1:0]   rdPtr;
   logic [PTR_W-1:0]   wrPtr;
   logic [WIDTH_p-1:0] headData;
   logic               pushEn;
   logic               popEn;
   logic               dropEn;

   // Pointer advance with an explicit wrap at the last entry.
   function automatic logic [PTR_W-1:0] ptrIncr(input logic [PTR_W-1:0] ptr);
      return (ptr == PTR_W'(DEPTH_p - 1)) ? '0 : ptr + PTR_W'(1);
   endfunction

   // Full and empty come from the registered occupancy count, so a push is
   // judged against the full flag as it stood at the clock edge. A full FIFO
   // drops the incoming result even if the head is popped in the same cycle.
   assign full      = (count == CNT_W'(DEPTH_p));
   assign empty     = (count == '0);
   assign pushEn    = in_valid & ~full;
   assign dropEn    = in_valid & full;
   assign popEn     = out_ready & ~empty;
   assign out_valid = ~empty;
   assign out_data  = empty ? '0 : headData;

   // Read/write pointers and occupancy. A simultaneous push and pop moves both
   // pointers and leaves the count where it was.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rdPtr <= '0;
         wrPtr <= '0;
         count <= '0;
      end else begin
         if (pushEn) begin
            wrPtr <= ptrIncr(wrPtr);
         end
         if (popEn) begin
            rdPtr <= ptrIncr(rdPtr);
         end
         case ({pushEn, popEn})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Drop counter and running sum. Clear wins over any increment in the same
   // cycle; the drop counter sticks at its maximum instead of wrapping, while
   // the sum is allowed to wrap.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         drop_cnt <= '0;
         sum      <= '0;
      end else if (clr) begin
         drop_cnt <= '0;
         sum      <= '0;
      end else begin
         if (dropEn && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + RB_DROP_W'(1);
         end
         if (pushEn) begin
            sum <= sum + SUM_W'(in_data);
         end
      end
   end

   result_buffer_mem #(
      .WIDTH_p (WIDTH_p),
      .DEPTH_p (DEPTH_p)
   ) memInst (
      .clk     (clk),
      .wr_en   (pushEn),
      .wr_addr (wrPtr),
      .wr_data (in_data),
      .rd_addr (rdPtr),
      .rd_data (headData)
   );

endmodule

// File: doc/result_buffer.md
RESULT_BUFFER -- requirements
Module: result_buffer

Interface
REQ-001 SHALL have parameter WIDTH_p, default 8, data width matching the upstream adder result.
REQ-002 SHALL have parameter DEPTH_p, default 4, number of FIFO entries; power of two, >= 2.
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rstn  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port in_valid  input  1  upstream result valid (driven by adder valid).
REQ-006 SHALL have port in_data  input  WIDTH_p  upstream result (driven by adder out).
REQ-007 SHALL have port clr  input  1  synchronous clear of drop_cnt and sum only.
REQ-008 SHALL have port out_ready  input  1  downstream ready for head entry.
REQ-009 SHALL have port out_valid  output  1  head entry present.
REQ-010 SHALL have port out_data  output  WIDTH_p  head entry data.
REQ-011 SHALL have port count  output  $clog2(DEPTH_p)+1  occupied entries.
REQ-012 SHALL have port full  output  1  count == DEPTH_p.
REQ-013 SHALL have port empty  output  1  count == 0.
REQ-014 SHALL have port drop_cnt  output  8  results lost while full, saturating.
REQ-015 SHALL have port sum  output  WIDTH_p+8  running modulo-2^(WIDTH_p+8) sum of accepted results.

Function
REQ-016 SHALL accept (push) in_data when in_valid=1 and full=0; full is the registered value at that edge.
REQ-017 SHALL drop in_data when in_valid=1 and full=1, even if a pop occurs in the same cycle; drop_cnt increments by 1, holding at 255.
REQ-018 SHALL pop the head when out_valid=1 and out_ready=1.
REQ-019 SHALL, on simultaneous push and pop, keep count unchanged and advance both pointers.
REQ-020 SHALL make pushed data visible at out_data no earlier than the cycle after the push; no bypass from in_data to out_data.
REQ-021 SHALL hold out_data and out_valid stable while out_valid=1 and out_ready=0.
REQ-022 SHALL drive out_valid = !empty; out_data SHALL be the oldest unpopped entry and is don't-care when empty.
REQ-023 SHALL wrap read and write pointers from DEPTH_p-1 to 0.
REQ-024 SHALL add zero-extended in_data to sum on each accepted push; dropped results are not added.
REQ-025 SHALL, when clr=1, set drop_cnt and sum to 0 next cycle, clr taking priority over a same-cycle increment; FIFO contents and count are unaffected.
REQ-026 SHALL ignore out_ready when empty and ignore in_valid=0 data.

Reset
REQ-027 SHALL, while rstn=0, force count=0, empty=1, full=0, out_valid=0, drop_cnt=0, sum=0, pointers=0, out_data=0.
REQ-028 SHALL discard all stored entries on reset mid-operation; the first push after release is the first entry read.
REQ-029 SHALL NOT reset storage array contents; they are unobservable while empty.

Structure
REQ-030 SHALL take default WIDTH_p, DEPTH_p and the drop counter width (8) from a shared package result_buffer_pkg.
REQ-031 SHALL implement storage as one sub-module result_buffer_mem (registered write, combinational read by pointer).
REQ-032 SHALL derive full/empty from the registered count, not from pointer comparison alone.

Verification
REQ-033 Reset, then push 0x11,0x22,0x33 with out_ready=0 -> count=3, out_data=0x11, sum=0x066.
REQ-034 Push 6 values 0x01..0x06 with DEPTH_p=4, out_ready=0 -> full=1, count=4, drop_cnt=2, sum=0x00A; pops return 0x01..0x04 in order.
REQ-035 From full, in_valid=1 and out_ready=1 in the same cycle -> new value dropped, drop_cnt+1, count=3.
REQ-036 One push and one pop per cycle for 10 cycles from count=2 -> count stays 2, read pointer wraps, data order preserved.
REQ-037 Assert rstn=0 with count=3 and drop_cnt=5 -> all outputs at reset values immediately; push 0xAA after release -> out_data=0xAA next cycle.
REQ-038 Pulse clr with sum=0x1FE and in_valid=1 accepted in the same cycle -> sum=0, drop_cnt=0, count incremented.
